// File: rtl/cdc_pkg.sv
// Shared types and constants for the bundled-data CDC receive endpoint.
package cdc_pkg;

    // Per-channel handshake state
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        ACK
    } cdc_hs_state_e;

    // Fewest synchroniser stages that still give a usable MTBF
    localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchroniser, asynchronous active-low reset to 0.
module cdc_sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[N-2:0], d};
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// Receive endpoint of a C-channel 4-phase bundled-data clock-domain crossing.
// Each channel synchronises its request, captures the data bundle once per
// handshake, offers it downstream as valid/ready and returns a registered ack.
// Optional macro CDC_HS_RX_ERR_EN adds a sticky per-channel protocol error
// flag (err) with a clear input (err_clr).
module cdc_hs_rx
    import cdc_pkg::*;
#(
    parameter int W           = 16,
    parameter int C           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [C-1:0]   req_i,
    input  logic [C*W-1:0] data_i,
    output logic [C-1:0]   ack_o,
    output logic [C-1:0]   out_valid,
    input  logic [C-1:0]   out_ready,
    output logic [C*W-1:0] out_data
`ifdef CDC_HS_RX_ERR_EN
   ,output logic [C-1:0]   err,
    input  logic [C-1:0]   err_clr
`endif
);

    generate
        if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
            $error("cdc_hs_rx: SYNC_STAGES below MIN_SYNC_STAGES");
        end
    endgenerate

    logic [C-1:0] req_s;

    genvar c;
    generate
        for (c = 0; c < C; c++) begin : g_ch

            cdc_hs_state_e state_q, state_d;
            logic [W-1:0]  data_q;
            logic          ack_q;
            logic          valid_c;

            cdc_sync_bit #(.N(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (req_i[c]),
                .q     (req_s[c])
            );

            // State register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) state_q <= IDLE;
                else        state_q <= state_d;
            end

            // Next-state: a request falling during HOLD does not leave HOLD;
            // the data stays offered until downstream takes it
            always_comb begin
                state_d = state_q;
                case (state_q)
                    IDLE:    if (req_s[c])                  state_d = HOLD;
                    HOLD:    if (out_ready[c])              state_d = ACK;
                    ACK:     if (!req_s[c])                 state_d = IDLE;
                    default:                                state_d = IDLE;
                endcase
            end

            // Outputs decoded from state
            always_comb begin
                valid_c = (state_q == HOLD);
            end

            // Capture the bundle only on the IDLE->HOLD edge; data_i is stable
            // by then because the sender holds it while req is high
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                              data_q <= '0;
                else if (state_q == IDLE && req_s[c])    data_q <= data_i[c*W +: W];
            end

            // Ack is its own flop so the sender sees a glitch-free signal
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ack_q <= 1'b0;
                else        ack_q <= (state_d == ACK);
            end

            assign out_valid[c]       = valid_c;
            assign ack_o[c]           = ack_q;
            assign out_data[c*W +: W] = data_q;

`ifdef CDC_HS_RX_ERR_EN
            logic err_q;

            // Sticky error: request dropped before acceptance; set beats clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) err_q <= 1'b0;
                else        err_q <= (state_q == HOLD && !req_s[c]) |
                                     (err_q & ~err_clr[c]);
            end

            assign err[c] = err_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Randomised bench for cdc_hs_rx with a transaction-level reference model,
// plus directed scenarios with literal expectations.
module tb_cdc_hs_rx;

    localparam int W = 16;
    localparam int C = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [C-1:0]   req;
    logic [C*W-1:0] data;
    logic [C-1:0]   ack_o;
    logic [C-1:0]   out_valid;
    logic [C-1:0]   out_ready;
    logic [C*W-1:0] out_data;
`ifdef CDC_HS_RX_ERR_EN
    logic [C-1:0]   err;
    logic [C-1:0]   err_clr;
`endif

    always #5 clk = ~clk;

    cdc_hs_rx #(.W(W), .C(C), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .data_i    (data),
        .ack_o     (ack_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef CDC_HS_RX_ERR_EN
       ,.err       (err),
        .err_clr   (err_clr)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: the receiver sees req delayed by S edges; one
    // captured word is pending until taken, then acked until req goes low.
    bit           m_pend [C];
    bit           m_ackd [C];
    bit           m_err  [C];
    logic [W-1:0] m_cap  [C];
    bit           m_hist [C][$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            m_pend[c] = 0; m_ackd[c] = 0; m_err[c] = 0; m_cap[c] = '0;
            m_hist[c] = {};
            for (int i = 0; i < S; i++) m_hist[c].push_back(1'b0);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < C; c++) begin
            bit rs;
            bit clr;
            rs  = m_hist[c][0];
            clr = 1'b0;
`ifdef CDC_HS_RX_ERR_EN
            clr = err_clr[c];
`endif
            m_err[c] = (m_pend[c] && !rs) || (m_err[c] && !clr);
            if (m_pend[c]) begin
                if (out_ready[c]) begin m_pend[c] = 0; m_ackd[c] = 1; end
            end else if (m_ackd[c]) begin
                if (!rs) m_ackd[c] = 0;
            end else if (rs) begin
                m_pend[c] = 1;
                m_cap[c]  = data[c*W +: W];
            end
            void'(m_hist[c].pop_front());
            m_hist[c].push_back(req[c]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < C; c++) begin
                chk($sformatf("valid%0d", c), 32'(out_valid[c]), 32'(m_pend[c]));
                chk($sformatf("ack%0d", c), 32'(ack_o[c]), 32'(m_ackd[c]));
                chk($sformatf("data%0d", c), 32'(out_data[c*W +: W]), 32'(m_cap[c]));
`ifdef CDC_HS_RX_ERR_EN
                chk($sformatf("err%0d", c), 32'(err[c]), 32'(m_err[c]));
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; data = '0; out_ready = '0;
`ifdef CDC_HS_RX_ERR_EN
        err_clr = '0;
`endif
        model_reset();
        #23;
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data[31:0]), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        chk_en = 1'b1;
        ticks(3);

        // Single transfer on channel 0 with backpressure
        req[0] = 1'b1; data[15:0] = 16'hA5C3;
        ticks(S);
        chk("lat_valid_early", 32'(out_valid[0]), 32'h0);
        tick();
        chk("lat_valid", 32'(out_valid[0]), 32'h1);
        chk("lat_data", 32'(out_data[15:0]), 32'hA5C3);
        data[15:0] = 16'hFFFF;
        ticks(20);
        chk("bp_data", 32'(out_data[15:0]), 32'hA5C3);
        chk("bp_ack", 32'(ack_o[0]), 32'h0);
        chk("bp_valid", 32'(out_valid[0]), 32'h1);
        out_ready[0] = 1'b1;
        tick();
        chk("acc_ack", 32'(ack_o[0]), 32'h1);
        chk("acc_valid", 32'(out_valid[0]), 32'h0);
        req[0] = 1'b0;
        ticks(S);
        chk("ackfall_early", 32'(ack_o[0]), 32'h1);
        tick();
        chk("ackfall", 32'(ack_o[0]), 32'h0);
        ticks(5);
        chk("ready_idle_noack", 32'(ack_o[0]), 32'h0);
        out_ready[0] = 1'b0;

        // Channels 1 and 3 together, only 3 ready
        req[1] = 1'b1; req[3] = 1'b1;
        data[16 +: 16] = 16'h0001; data[48 +: 16] = 16'h0003;
        out_ready[3] = 1'b1;
        ticks(S + 1);
        chk("ind_valid", 32'(out_valid), 32'ha);
        tick();
        chk("ind_ack", 32'(ack_o), 32'h8);
        chk("ind_valid2", 32'(out_valid), 32'h2);
        chk("ind_data1", 32'(out_data[16 +: 16]), 32'h0001);
        req[3] = 1'b0;
        ticks(S + 1);
        chk("ind_ack3_fall", 32'(ack_o[3]), 32'h0);
        chk("ind_hold1", 32'(out_data[16 +: 16]), 32'h0001);
        out_ready = '0;

`ifdef CDC_HS_RX_ERR_EN
        // Request drop while holding on channel 2
        req[2] = 1'b1; data[32 +: 16] = 16'h2222;
        ticks(S + 1);
        req[2] = 1'b0;
        ticks(S);
        chk("err_early", 32'(err[2]), 32'h0);
        tick();
        chk("err_set", 32'(err[2]), 32'h1);
        err_clr[2] = 1'b1;
        tick();
        err_clr[2] = 1'b0;
        chk("err_set_wins", 32'(err[2]), 32'h1);
        out_ready[2] = 1'b1;
        ticks(3);
        out_ready[2] = 1'b0;
        chk("err_sticky", 32'(err[2]), 32'h1);
        err_clr[2] = 1'b1;
        tick();
        err_clr[2] = 1'b0;
        chk("err_clr", 32'(err[2]), 32'h0);
`endif

        // Channel 1 into ACK, then reset mid-cycle
        out_ready[1] = 1'b1;
        tick();
        out_ready[1] = 1'b0;
        chk("pre_rst_ack", 32'(ack_o[1]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ack", 32'(ack_o), 32'h0);
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_data", 32'(out_data[31:0]), 32'h0);
        model_reset();
        req = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        ticks(2);

        // Randomised traffic: well-behaved senders with rare early drops
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < C; c++) begin
                if (!req[c]) begin
                    if (!ack_o[c] && $urandom_range(0, 3) == 0) begin
                        data[c*W +: W] = W'($urandom);
                        req[c] = 1'b1;
                    end else if ($urandom_range(0, 1) == 0) begin
                        data[c*W +: W] = W'($urandom);
                    end
                end else if (ack_o[c] && $urandom_range(0, 2) == 0) begin
                    req[c] = 1'b0;
                end else if (out_valid[c] && $urandom_range(0, 99) == 0) begin
                    req[c] = 1'b0;
                end
            end
            out_ready = C'($urandom);
`ifdef CDC_HS_RX_ERR_EN
            for (int c = 0; c < C; c++) err_clr[c] = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
